// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq
// Purpose  : Instruction-fetch sequencer. Owns the PC, issues one fetch at a
//            time to instruction memory (req/ack), presents each fetched word
//            downstream on a valid/ready handshake and applies PC-relative
//            redirects computed from the PC of the last accepted instruction.
// Ports    : clk             - clock, all state updates on rising edge
//            rst             - asynchronous active-low reset
//            redirect_valid  - one-cycle redirect pulse
//            redirect_offset - signed byte offset, low ADDRESS_WIDTH bits used
//            mem_req/mem_addr/mem_ack/mem_rdata - instruction memory port
//            instr_valid/instr_ready/instr/instr_pc - downstream handshake
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq #(
    parameter int                       ADDRESS_WIDTH = 12,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [DATA_WIDTH-1:0]    redirect_offset,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;

    localparam logic [ADDRESS_WIDTH-1:0] c_pc_step    = ADDRESS_WIDTH'(4);
    localparam logic [ADDRESS_WIDTH-1:0] c_align_mask = ~ADDRESS_WIDTH'(3);

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] w_pc_nxt;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] w_addr_nxt;
    logic [ADDRESS_WIDTH-1:0] r_last_pc;
    logic [ADDRESS_WIDTH-1:0] w_last_pc_nxt;
    logic                     r_kill;
    logic                     w_kill_nxt;
    logic [DATA_WIDTH-1:0]    r_instr;
    logic [DATA_WIDTH-1:0]    w_instr_nxt;
    logic [ADDRESS_WIDTH-1:0] r_instr_pc;
    logic [ADDRESS_WIDTH-1:0] w_instr_pc_nxt;

    logic [ADDRESS_WIDTH-1:0] w_target_sum;
    logic [ADDRESS_WIDTH-1:0] w_target;

    // Only the low ADDRESS_WIDTH offset bits matter: PC arithmetic wraps.
    generate
        if (DATA_WIDTH > ADDRESS_WIDTH) begin : g_offset_hi
            logic w_unused_offset_hi;
            assign w_unused_offset_hi = ^redirect_offset[DATA_WIDTH-1:ADDRESS_WIDTH];
        end
    endgenerate

    // Redirect target is relative to the last accepted instruction, taken
    // before any same-cycle acceptance updates it, then word-aligned.
    assign w_target_sum = r_last_pc + redirect_offset[ADDRESS_WIDTH-1:0];
    assign w_target     = w_target_sum & c_align_mask;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_last_pc_nxt  = r_last_pc;
        w_kill_nxt     = r_kill;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;

        case (r_state)
            c_st_idle: begin
                w_state_nxt = c_st_fetch;
                if (redirect_valid) begin
                    w_pc_nxt = w_target;
                end
            end
            c_st_fetch: begin
                if (mem_ack) begin
                    if (redirect_valid) begin
                        // Returned word belongs to the old stream.
                        w_pc_nxt   = w_target;
                        w_kill_nxt = 1'b0;
                    end else if (r_kill) begin
                        // This ack retires the request issued before the
                        // redirect; r_pc already holds the new target.
                        w_kill_nxt = 1'b0;
                    end else begin
                        w_instr_nxt    = mem_rdata;
                        w_instr_pc_nxt = r_pc;
                        w_state_nxt    = c_st_hold;
                    end
                end else if (redirect_valid) begin
                    // Request stays outstanding at its old address; its data
                    // is dropped when it finally returns.
                    w_pc_nxt   = w_target;
                    w_kill_nxt = 1'b1;
                end
            end
            c_st_hold: begin
                if (instr_ready) begin
                    w_last_pc_nxt = r_instr_pc;
                end
                if (redirect_valid) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = c_st_fetch;
                end else if (instr_ready) begin
                    w_pc_nxt    = r_instr_pc + c_pc_step;
                    w_state_nxt = c_st_fetch;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        // The presented address may only move once the pending request retires.
        if ((r_state == c_st_fetch) && !mem_ack) begin
            w_addr_nxt = r_addr;
        end else begin
            w_addr_nxt = w_pc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_last_pc  <= RESET_PC;
            r_kill     <= 1'b0;
            r_instr    <= '0;
            r_instr_pc <= RESET_PC;
        end else begin
            r_pc       <= w_pc_nxt;
            r_addr     <= w_addr_nxt;
            r_last_pc  <= w_last_pc_nxt;
            r_kill     <= w_kill_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        case (r_state)
            c_st_fetch: mem_req     = 1'b1;
            c_st_hold:  instr_valid = 1'b1;
            default: begin
            end
        endcase
    end

    assign mem_addr = r_addr;
    assign instr    = r_instr;
    assign instr_pc = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_seq
// Purpose  : Self-checking bench for fetch_seq. Directed steps walk through
//            zero-wait fetch, delayed ack, downstream stall, redirects in each
//            state, PC wrap and mid-fetch reset; a randomized phase follows.
//            Delivered instructions are scored against a stream-level model:
//            the next expected PC is last-accepted+4, or the redirect target
//            (from the pre-update last accepted PC) if a redirect intervened.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_seq;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect_valid;
    logic [DW-1:0] redirect_offset;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;

    // Second instance with a PC near the top of the address space.
    logic          wr_mem_req;
    logic [AW-1:0] wr_mem_addr;
    logic          wr_instr_valid;
    logic [DW-1:0] wr_instr;
    logic [AW-1:0] wr_instr_pc;

    int errors = 0;
    int checks = 0;
    int n_acc  = 0;

    logic [AW-1:0] m_exp;
    logic [AW-1:0] m_last;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a, 8'h5A, ~a};
    endfunction

    fetch_seq #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(12'h000)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_offset (redirect_offset),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    fetch_seq #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(12'hFFC)) u_wrap (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (1'b0),
        .redirect_offset ({DW{1'b0}}),
        .mem_req         (wr_mem_req),
        .mem_addr        (wr_mem_addr),
        .mem_ack         (wr_mem_req),
        .mem_rdata       (mem_word(wr_mem_addr)),
        .instr_valid     (wr_instr_valid),
        .instr_ready     (1'b1),
        .instr           (wr_instr),
        .instr_pc        (wr_instr_pc)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_exp  = 12'h000;
        m_last = 12'h000;
    endtask

    // Called at a falling edge: drives inputs, scores what the coming rising
    // edge will do, then advances to the next falling edge.
    task automatic tick(input bit ack, input bit rdy, input bit rv, input logic [DW-1:0] off);
        logic [AW-1:0] tgt;
        bit            acc;
        bit            wait_req;
        logic [AW-1:0] wait_addr;
        bit            hold;
        logic [AW-1:0] hold_pc;
        logic [DW-1:0] hold_instr;

        mem_ack         = ack;
        mem_rdata       = mem_req ? mem_word(mem_addr) : DW'($urandom);
        instr_ready     = rdy;
        redirect_valid  = rv;
        redirect_offset = off;

        acc = instr_valid && rdy;
        tgt = '0;
        if (acc) begin
            chk("accept_pc", DW'(instr_pc), DW'(m_exp));
            chk("accept_data", instr, mem_word(instr_pc));
            n_acc++;
        end
        if (rv) tgt = (m_last + off[AW-1:0]) & 12'hFFC;
        if (acc) m_last = instr_pc;
        if (rv) m_exp = tgt;
        else if (acc) m_exp = instr_pc + 12'd4;

        wait_req   = mem_req && !ack;
        wait_addr  = mem_addr;
        hold       = instr_valid && !rdy && !rv;
        hold_pc    = instr_pc;
        hold_instr = instr;

        @(negedge clk);

        if (wait_req) begin
            chk("req_held", DW'(mem_req), 1);
            chk("addr_stable", DW'(mem_addr), DW'(wait_addr));
        end
        if (hold) begin
            chk("valid_held", DW'(instr_valid), 1);
            chk("hold_pc", DW'(instr_pc), DW'(hold_pc));
            chk("hold_instr", instr, hold_instr);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic [AW-1:0] a);
        chk({tag, "_req"}, DW'(mem_req), 1);
        chk({tag, "_addr"}, DW'(mem_addr), DW'(a));
        chk({tag, "_nvalid"}, DW'(instr_valid), 0);
    endtask

    task automatic chk_hold(input string tag, input logic [AW-1:0] a);
        chk({tag, "_valid"}, DW'(instr_valid), 1);
        chk({tag, "_pc"}, DW'(instr_pc), DW'(a));
        chk({tag, "_nreq"}, DW'(mem_req), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, DW'(mem_req), 0);
        chk({tag, "_addr"}, DW'(mem_addr), 0);
        chk({tag, "_valid"}, DW'(instr_valid), 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_ipc"}, DW'(instr_pc), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b0;
        redirect_valid  = 1'b0;
        redirect_offset = '0;
        mem_ack         = 1'b0;
        mem_rdata       = '0;
        instr_ready     = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        chk("wrap_reset_addr", DW'(wr_mem_addr), DW'(12'hFFC));
        rst = 1'b1;

        // IDLE cycle after release
        chk("idle_nreq", DW'(mem_req), 0);
        tick(0, 1, 0, 0);

        // Zero-wait memory, ready=1: one instruction every 2 cycles
        for (int k = 0; k < 3; k++) begin
            chk_fetch("zw_fetch", AW'(4 * k));
            if (k == 0) chk("wrap_first_addr", DW'(wr_mem_addr), DW'(12'hFFC));
            if (k == 1) chk("wrap_next_addr", DW'(wr_mem_addr), DW'(12'h000));
            tick(mem_req, 1, 0, 0);
            chk_hold("zw_hold", AW'(4 * k));
            if (k == 0) chk("wrap_hold_pc", DW'(wr_instr_pc), DW'(12'hFFC));
            tick(0, 1, 0, 0);
        end

        // Ack delayed 3 cycles on 0x00C
        for (int i = 0; i < 4; i++) begin
            chk_fetch("slow_fetch", 12'h00C);
            tick(i == 3, 1, 0, 0);
        end
        chk_hold("slow_hold", 12'h00C);
        tick(0, 1, 0, 0);

        // Downstream stall on 0x010
        chk_fetch("stall_fetch", 12'h010);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk_hold("stall_hold", 12'h010);
            chk("stall_instr", instr, mem_word(12'h010));
            tick(0, 0, 0, 0);
        end
        tick(0, 1, 0, 0);

        // Redirect -8 from last_pc 0x010 while fetch of 0x014 outstanding
        chk_fetch("kill_fetch", 12'h014);
        tick(0, 0, 1, 32'hFFFF_FFF8);
        chk_fetch("kill_old", 12'h014);
        tick(1, 0, 0, 0);
        chk_fetch("kill_new", 12'h008);
        tick(1, 1, 0, 0);
        chk_hold("kill_hold", 12'h008);
        tick(0, 1, 0, 0);

        // Redirect +0xF8 from 0x008 -> 0x100, then +7 from 0x100 -> 0x104
        tick(0, 1, 1, 32'h0000_00F8);
        chk_fetch("r100_old", 12'h00C);
        tick(1, 1, 0, 0);
        chk_fetch("r100_new", 12'h100);
        tick(1, 1, 0, 0);
        tick(0, 1, 0, 0);
        chk_fetch("r7_fetch", 12'h104);
        tick(1, 1, 1, 32'h0000_0007);
        chk_fetch("r7_new", 12'h104);
        tick(1, 1, 0, 0);
        chk_hold("r7_hold", 12'h104);
        tick(0, 1, 0, 0);

        // Redirect with handshake in HOLD: target from pre-update last_pc 0x104
        tick(1, 1, 0, 0);
        chk_hold("hsr_hold", 12'h108);
        tick(0, 1, 1, 32'h0000_0010);
        chk_fetch("hsr_fetch", 12'h114);
        tick(1, 1, 0, 0);
        // Redirect in HOLD without handshake: drop, target from 0x108
        tick(0, 0, 1, 32'hFFFF_FFFC);
        chk_fetch("drop_fetch", 12'h104);
        tick(0, 1, 0, 0);

        // Asynchronous reset in the middle of a fetch
        #2 rst = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(negedge clk);
        mem_ack = 1'b1;
        rst     = 1'b1;
        model_reset();
        chk("late_ack_nreq", DW'(mem_req), 0);
        tick(1, 1, 0, 0);
        chk_fetch("post_reset", 12'h000);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            tick(mem_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 15) == 0,
                 DW'($urandom));
        end
        chk("liveness", DW'(n_acc > 200), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
